// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between N_REQ clients,
// with bounded bursts and a tag pipeline that routes read data to its issuer.
module bram_port_arbiter #(
    parameter int N_REQ           = 2,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_BURST       = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ-1:0]                     we_i,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0]       addr_i,
    input  logic [N_REQ*BRAM_DATA_WIDTH-1:0]     wdata_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [N_REQ-1:0]                     rvalid_o,
    output logic [BRAM_DATA_WIDTH-1:0]           rdata_o,
    output logic [ADDRESS_WIDTH-1:0]             bram_addr,
    output logic                                 bram_en,
    output logic                                 bram_we,
    output logic [BRAM_DATA_WIDTH-1:0]           bram_data_in,
    input  logic [BRAM_DATA_WIDTH-1:0]           bram_data_out
);

    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, OWN} state_t;

    state_t                          state;
    logic [IDW-1:0]                  owner;
    logic [IDW-1:0]                  rr_ptr;
    logic [IDW-1:0]                  next_owner;
    logic                            found;
    logic [CNTW-1:0]                 beat_cnt;
    logic [ADDRESS_WIDTH-1:0]        addr_q;
    logic [BRAM_DATA_WIDTH-1:0]      data_q;
    logic [ADDRESS_WIDTH-1:0]        owner_addr;
    logic [BRAM_DATA_WIDTH-1:0]      owner_wdata;
    logic                            beat;
    logic                            release_now;
    logic [RD_LATENCY-1:0][IDW:0]    tag_pipe;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    assign owner_addr  = addr_i[owner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign owner_wdata = wdata_i[owner*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
    assign beat        = (state == OWN) && req_i[owner];
    // The beat that fills the burst is still performed before releasing.
    assign release_now = !req_i[owner] || (beat_cnt == CNTW'(MAX_BURST - 1));

    always_comb begin
        found      = 1'b0;
        next_owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[(int'(rr_ptr) + i) % N_REQ]) begin
                found      = 1'b1;
                next_owner = IDW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt_o    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= {beat & ~we_i[owner], owner};
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (beat) begin
                addr_q   <= owner_addr;
                data_q   <= owner_wdata;
                beat_cnt <= beat_cnt + CNTW'(1);
            end
            case (state)
                ARB: begin
                    if (found) begin
                        owner    <= next_owner;
                        beat_cnt <= '0;
                        gnt_o    <= N_REQ'(1) << next_owner;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        gnt_o  <= '0;
                        rr_ptr <= wrap_inc(owner);
                        state  <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Address and data hold their last beat values between accesses.
    assign bram_en      = beat;
    assign bram_we      = beat & we_i[owner];
    assign bram_addr    = beat ? owner_addr  : addr_q;
    assign bram_data_in = beat ? owner_wdata : data_q;
    assign rdata_o      = rst_i ? '0 : bram_data_out;

    always_comb begin
        rvalid_o = '0;
        if (tag_pipe[RD_LATENCY-1][IDW]) begin
            rvalid_o[tag_pipe[RD_LATENCY-1][IDW-1:0]] = 1'b1;
        end
    end

endmodule
